// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch / decode path.
//   - ADDR_W_DEF / INSTR_W_DEF : default address and instruction widths
//   - field bit positions inside a 16-bit instruction word
//   - opcode_e : architectural opcodes (8..E are illegal)
//   - state_e  : decode/issue FSM states
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 16;

    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_MSB  = 11;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_MSB = 7;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 0;
    localparam int unsigned IMM_MSB = 7;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_JMP  = 4'h7,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LATCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational split of the instruction register.
//   ir      in  : instruction register contents
//   opcode  out : decoded opcode, illegal encodings mapped to OP_NOP
//   illegal out : opcode field is one of 8..E
//   is_jmp  out : opcode is JMP
//   is_halt out : opcode is HALT
//   rd/rs1/rs2/imm out : raw operand fields
module instr_field_decode
    import fetch_pkg::*;
#(
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic [INSTR_W-1:0] ir,
    output opcode_e            opcode,
    output logic               illegal,
    output logic               is_jmp,
    output logic               is_halt,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [7:0]         imm
);

    logic [3:0] opc_raw;

    assign opc_raw = ir[OPC_MSB:OPC_LSB];
    assign rd      = ir[RD_MSB:RD_LSB];
    assign rs1     = ir[RS1_MSB:RS1_LSB];
    assign rs2     = ir[RS2_MSB:RS2_LSB];
    assign imm     = ir[IMM_MSB:IMM_LSB];

    always_comb begin
        opcode  = OP_NOP;
        illegal = 1'b0;
        case (opc_raw)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF:
                opcode = opcode_e'(opc_raw);
            default:
                illegal = 1'b1;
        endcase
        is_jmp  = (opcode == OP_JMP);
        is_halt = (opcode == OP_HALT);
    end

endmodule

// File: rtl/decode_issue_unit.sv
// decode_issue_unit: fetches a word from synchronous instruction memory,
// latches and decodes it, and issues it to execute over valid/ready.
//   clk, reset (async, active-low)
//   pc_value  in  : current PC / memory address
//   instr_in  in  : memory read data (one cycle after address)
//   en_pc     out : PC load enable, pulses on accepted non-HALT instruction
//   pc_next   out : PC load value (jump target or pc_value+1)
//   dec_valid/dec_ready : issue handshake
//   dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_imm : decoded fields
//   illegal_op out : presented instruction had an illegal opcode
//   halted     out : sticky, set once HALT is accepted
module decode_issue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_value,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               en_pc,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [3:0]         dec_opcode,
    output logic [3:0]         dec_rd,
    output logic [3:0]         dec_rs1,
    output logic [3:0]         dec_rs2,
    output logic [7:0]         dec_imm,
    output logic               illegal_op,
    output logic               halted
);

    state_e             state_q, state_d;
    logic               run_q, run_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               dec_valid_q, dec_valid_d;
    logic               halted_q, halted_d;

    opcode_e            op;
    logic               illegal;
    logic               is_jmp;
    logic               is_halt;

    instr_field_decode #(
        .INSTR_W (INSTR_W)
    ) u_decode (
        .ir      (ir_q),
        .opcode  (op),
        .illegal (illegal),
        .is_jmp  (is_jmp),
        .is_halt (is_halt),
        .rd      (dec_rd),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .imm     (dec_imm)
    );

    // The first cycle after reset release is spent in FETCH without advancing:
    // the PC register and memory are leaving reset on the same edge, so the
    // memory address is only guaranteed stable from the following cycle.
    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
        ir_d        = ir_q;
        dec_valid_d = dec_valid_q;
        halted_d    = halted_q;
        case (state_q)
            ST_FETCH: begin
                if (run_q) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                ir_d        = instr_in;
                dec_valid_d = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (dec_ready) begin
                    dec_valid_d = 1'b0;
                    if (is_halt) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            run_q       <= 1'b0;
            ir_q        <= '0;
            dec_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            ir_q        <= ir_d;
            dec_valid_q <= dec_valid_d;
            halted_q    <= halted_d;
        end
    end

    assign dec_valid  = dec_valid_q;
    assign dec_opcode = op;
    assign illegal_op = dec_valid_q & illegal;
    assign halted     = halted_q;
    assign en_pc      = (state_q == ST_ISSUE) && dec_ready && !is_halt;
    assign pc_next    = is_jmp ? ADDR_W'(dec_imm) : pc_value + ADDR_W'(1);

endmodule

// File: tb/tb_decode_issue_unit.sv
// tb_decode_issue_unit: directed test of decode_issue_unit with a small PC
// register and synchronous instruction memory model around it.
module tb_decode_issue_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  pc_value;
    logic [15:0] instr_in;
    logic        en_pc;
    logic [7:0]  pc_next;
    logic        dec_valid;
    logic        dec_ready;
    logic [3:0]  dec_opcode;
    logic [3:0]  dec_rd;
    logic [3:0]  dec_rs1;
    logic [3:0]  dec_rs2;
    logic [7:0]  dec_imm;
    logic        illegal_op;
    logic        halted;

    logic [15:0] mem [0:255];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    decode_issue_unit #(
        .ADDR_W  (8),
        .INSTR_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_value   (pc_value),
        .instr_in   (instr_in),
        .en_pc      (en_pc),
        .pc_next    (pc_next),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .dec_opcode (dec_opcode),
        .dec_rd     (dec_rd),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_imm    (dec_imm),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    // PC register and synchronous memory
    always @(posedge clk or negedge reset) begin
        if (!reset)     pc_value <= 8'h00;
        else if (en_pc) pc_value <= pc_next;
    end

    always @(posedge clk) instr_in <= mem[pc_value];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (dec_valid !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, {31'd0, dec_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1123;
        mem[8'h01] = 16'h7005;
        mem[8'h05] = 16'h7040;
        mem[8'h40] = 16'h2456;
        mem[8'h41] = 16'h70FF;
        mem[8'hFF] = 16'h0000;

        reset     = 1'b0;
        dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",   {31'd0, dec_valid},  32'd0);
        check("rst_en_pc",   {31'd0, en_pc},      32'd0);
        check("rst_halted",  {31'd0, halted},     32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        check("rst_opcode",  {28'd0, dec_opcode}, 32'd0);
        check("rst_fields",  {12'd0, dec_rd, dec_rs1, dec_rs2, dec_imm}, 32'd0);

        // first instruction: valid on the third edge after release
        @(negedge clk);
        reset     = 1'b1;
        dec_ready = 1'b1;
        tick();
        check("e1_valid", {31'd0, dec_valid}, 32'd0);
        tick();
        check("e2_valid", {31'd0, dec_valid}, 32'd0);
        tick();
        check("e3_valid",  {31'd0, dec_valid},  32'd1);
        check("add_op",    {28'd0, dec_opcode}, 32'd1);
        check("add_rd",    {28'd0, dec_rd},     32'd1);
        check("add_rs1",   {28'd0, dec_rs1},    32'd2);
        check("add_rs2",   {28'd0, dec_rs2},    32'd3);
        check("add_en_pc", {31'd0, en_pc},      32'd1);
        check("add_pcn",   {24'd0, pc_next},    32'h01);
        tick();
        check("add_after_valid", {31'd0, dec_valid}, 32'd0);
        check("add_after_en_pc", {31'd0, en_pc},     32'd0);

        // JMP 0x05, then JMP 0x40 from pc 0x05
        wait_valid("wait_jmp5", 10);
        check("jmp5_op",  {28'd0, dec_opcode}, 32'd7);
        check("jmp5_pcn", {24'd0, pc_next},    32'h05);
        tick();
        wait_valid("wait_jmp40", 10);
        check("jmp40_op",    {28'd0, dec_opcode}, 32'd7);
        check("jmp40_en_pc", {31'd0, en_pc},      32'd1);
        check("jmp40_pcn",   {24'd0, pc_next},    32'h40);
        tick();
        dec_ready = 1'b0;

        // backpressure on the SUB fetched from 0x40
        wait_valid("wait_sub", 10);
        for (int c = 0; c < 4; c++) begin
            check("bp_valid", {31'd0, dec_valid},  32'd1);
            check("bp_op",    {28'd0, dec_opcode}, 32'd2);
            check("bp_fields", {20'd0, dec_rd, dec_rs1, dec_rs2}, 32'h456);
            check("bp_en_pc", {31'd0, en_pc},      32'd0);
            tick();
        end
        dec_ready = 1'b1;
        #1;
        check("bp_accept_en_pc", {31'd0, en_pc},   32'd1);
        check("bp_accept_pcn",   {24'd0, pc_next}, 32'h41);
        mem[8'h00] = 16'h9ABC;
        mem[8'h01] = 16'hF000;
        tick();
        check("bp_single_pulse", {31'd0, en_pc},     32'd0);
        check("bp_after_valid",  {31'd0, dec_valid}, 32'd0);

        // JMP 0xFF, NOP at 0xFF wraps to 0x00
        wait_valid("wait_jmpff", 10);
        check("jmpff_pcn", {24'd0, pc_next}, 32'hFF);
        tick();
        wait_valid("wait_nop", 10);
        check("nop_op",   {28'd0, dec_opcode}, 32'd0);
        check("nop_ill",  {31'd0, illegal_op}, 32'd0);
        check("nop_wrap", {24'd0, pc_next},    32'h00);
        tick();

        // illegal 0x9ABC at pc 0x00
        wait_valid("wait_ill", 10);
        check("ill_op",    {28'd0, dec_opcode}, 32'd0);
        check("ill_flag",  {31'd0, illegal_op}, 32'd1);
        check("ill_rd",    {28'd0, dec_rd},     32'hA);
        check("ill_imm",   {24'd0, dec_imm},    32'hBC);
        check("ill_en_pc", {31'd0, en_pc},      32'd1);
        check("ill_pcn",   {24'd0, pc_next},    32'h01);
        tick();
        check("ill_after_flag", {31'd0, illegal_op}, 32'd0);

        // HALT at pc 0x01
        wait_valid("wait_halt", 10);
        check("halt_op",    {28'd0, dec_opcode}, 32'hF);
        check("halt_en_pc", {31'd0, en_pc},      32'd0);
        check("halt_pre",   {31'd0, halted},     32'd0);
        tick();
        check("halt_set",   {31'd0, halted},     32'd1);
        for (int c = 0; c < 20; c++) begin
            dec_ready = c[0];
            #1;
            check("halt_en_pc_hold", {31'd0, en_pc},     32'd0);
            check("halt_valid_hold", {31'd0, dec_valid}, 32'd0);
            check("halt_sticky",     {31'd0, halted},    32'd1);
            tick();
        end

        // reset mid-ISSUE under backpressure
        mem[8'h00] = 16'h1123;
        reset      = 1'b0;
        dec_ready  = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        wait_valid("wait_issue2", 10);
        check("mid_op", {28'd0, dec_opcode}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid",  {31'd0, dec_valid}, 32'd0);
        check("mid_rst_halted", {31'd0, halted},    32'd0);
        check("mid_rst_en_pc",  {31'd0, en_pc},     32'd0);
        @(negedge clk);
        reset     = 1'b1;
        dec_ready = 1'b1;
        tick();
        check("re_e1_valid", {31'd0, dec_valid}, 32'd0);
        tick();
        check("re_e2_valid", {31'd0, dec_valid}, 32'd0);
        tick();
        check("re_e3_valid", {31'd0, dec_valid},  32'd1);
        check("re_op",       {28'd0, dec_opcode}, 32'd1);
        check("re_pcn",      {24'd0, pc_next},    32'h01);
        check("re_halted",   {31'd0, halted},     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
